// File: rtl/arbitro_ula_pkg.sv
// Shared definitions for the two-requester arbiter in front of an external ULA.
package arbitro_ula_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        StOcioso   = 2'd0,
        StExecuta  = 2'd1,
        StResponde = 2'd2
    } estado_t;

endpackage

// File: rtl/seletor_rr.sv
// Two-way round-robin selector: the pointer only matters when both requests are high.
module seletor_rr (
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic valido_o,
    output logic vencedor_o
);

    always_comb begin
        valido_o   = req0_i | req1_i;
        vencedor_o = (req0_i & req1_i) ? ptr_i : req1_i;
    end

endmodule

// File: rtl/arbitro_ula.sv
// Arbitrates two requesters onto one external ULA, one transaction at a time,
// registering the result and returning it with a Done pulse to the winner.
module arbitro_ula
    import arbitro_ula_pkg::*;
#(
    parameter int unsigned ESPERA = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [OP_W-1:0]   Op0,
    input  logic [OP_W-1:0]   Op1,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] B0,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] B1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Done0,
    output logic              Done1,
    output logic [DATA_W-1:0] Entrada1,
    output logic [DATA_W-1:0] Entrada2,
    output logic [OP_W-1:0]   ALUOp,
    input  logic [DATA_W-1:0] Resultado,
    input  logic              Zero,
    output logic [DATA_W-1:0] ResultadoOut,
    output logic              ZeroOut,
    output logic              Ocupado
);

    // The first EXECUTA cycle carries the grant pulse; ESPERA+1 counted cycles follow it.
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(ESPERA + 1);

    estado_t           estado_q, estado_d;
    logic              ptr_q, ptr_d;
    logic              vencedor_q, vencedor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;

    logic sel_valido;
    logic sel_vencedor;

    seletor_rr u_seletor_rr (
        .req0_i     (Req0),
        .req1_i     (Req1),
        .ptr_i      (ptr_q),
        .valido_o   (sel_valido),
        .vencedor_o (sel_vencedor)
    );

    always_comb begin
        estado_d   = estado_q;
        ptr_d      = ptr_q;
        vencedor_d = vencedor_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        gnt_d      = 2'b00;
        res_d      = res_q;
        zero_d     = zero_q;
        unique case (estado_q)
            StOcioso: begin
                if (sel_valido) begin
                    vencedor_d = sel_vencedor;
                    op_d       = sel_vencedor ? Op1 : Op0;
                    a_d        = sel_vencedor ? A1 : A0;
                    b_d        = sel_vencedor ? B1 : B0;
                    gnt_d      = sel_vencedor ? 2'b10 : 2'b01;
                    cnt_d      = '0;
                    estado_d   = StExecuta;
                end
            end
            StExecuta: begin
                if (cnt_q == ULTIMO) begin
                    res_d    = Resultado;
                    zero_d   = Zero;
                    estado_d = StResponde;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResponde: begin
                ptr_d    = ~vencedor_q;
                cnt_d    = '0;
                estado_d = StOcioso;
            end
            default: estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= StOcioso;
            ptr_q      <= 1'b0;
            vencedor_q <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            gnt_q      <= 2'b00;
            res_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            ptr_q      <= ptr_d;
            vencedor_q <= vencedor_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            gnt_q      <= gnt_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
        end
    end

    always_comb begin
        Gnt0         = gnt_q[0];
        Gnt1         = gnt_q[1];
        Done0        = (estado_q == StResponde) && !vencedor_q;
        Done1        = (estado_q == StResponde) && vencedor_q;
        Ocupado      = (estado_q != StOcioso);
        Entrada1     = '0;
        Entrada2     = '0;
        ALUOp        = '0;
        if (estado_q != StOcioso) begin
            Entrada1 = a_q;
            Entrada2 = b_q;
            ALUOp    = op_q;
        end
        ResultadoOut = res_q;
        ZeroOut      = zero_q;
    end

endmodule

// File: tb/tb_arbitro_ula.sv
// Randomized scoreboard bench for arbitro_ula with a transaction-level reference model.
module tb_arbitro_ula;

    localparam int unsigned E = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Req0 = 1'b0, Req1 = 1'b0;
    logic [1:0] Op0 = '0, Op1 = '0;
    logic [7:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic       Gnt0, Gnt1, Done0, Done1, ZeroOut, Ocupado, Zero;
    logic [7:0] Entrada1, Entrada2, Resultado, ResultadoOut;
    logic [1:0] ALUOp;

    int unsigned checks = 0;
    int unsigned errors = 0;

    arbitro_ula #(.ESPERA(E)) dut (
        .clock        (clock),
        .reset        (reset),
        .Req0         (Req0),
        .Req1         (Req1),
        .Op0          (Op0),
        .Op1          (Op1),
        .A0           (A0),
        .B0           (B0),
        .A1           (A1),
        .B1           (B1),
        .Gnt0         (Gnt0),
        .Gnt1         (Gnt1),
        .Done0        (Done0),
        .Done1        (Done1),
        .Entrada1     (Entrada1),
        .Entrada2     (Entrada2),
        .ALUOp        (ALUOp),
        .Resultado    (Resultado),
        .Zero         (Zero),
        .ResultadoOut (ResultadoOut),
        .ZeroOut      (ZeroOut),
        .Ocupado      (Ocupado)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ula(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // External ULA stub
    assign Resultado = ula(ALUOp, Entrada1, Entrada2);
    assign Zero      = (Resultado == 8'h00);

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          win;
        int unsigned t0;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        logic        zero;
    } tr_t;

    tr_t         exp_q[$];
    tr_t         cur;
    bit          gnt_log[$];
    int unsigned edge_n = 0;
    int unsigned livre = 0;
    bit          ativo = 0;
    bit          ptr = 0;
    logic [7:0]  ult_res = '0;
    logic        ult_zero = 1'b0;
    logic [1:0]  exp_gnt = '0, exp_done = '0, exp_op = '0;
    logic        exp_busy = 1'b0;
    logic [7:0]  exp_e1 = '0, exp_e2 = '0;

    // Reference model: a transaction accepted at edge t0 is busy for E+3 cycles,
    // Done in the cycle starting at t0+E+2, next acceptance no earlier than t0+E+4.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                edge_n = 0; livre = 0; ativo = 0; ptr = 0;
                ult_res = '0; ult_zero = 1'b0;
                exp_gnt = '0; exp_done = '0; exp_busy = 1'b0;
                exp_e1 = '0; exp_e2 = '0; exp_op = '0;
                exp_q.delete();
            end else begin
                edge_n++;
                if (!ativo && edge_n >= livre && (Req0 || Req1)) begin
                    cur.win  = (Req0 && Req1) ? ptr : Req1;
                    cur.t0   = edge_n;
                    cur.op   = cur.win ? Op1 : Op0;
                    cur.a    = cur.win ? A1 : A0;
                    cur.b    = cur.win ? B1 : B0;
                    cur.res  = ula(cur.op, cur.a, cur.b);
                    cur.zero = (cur.res == 8'h00);
                    exp_q.push_back(cur);
                    ativo = 1;
                end
                exp_gnt = '0; exp_done = '0; exp_busy = 1'b0;
                exp_e1 = '0; exp_e2 = '0; exp_op = '0;
                if (ativo) begin
                    exp_busy = 1'b1;
                    exp_e1 = cur.a; exp_e2 = cur.b; exp_op = cur.op;
                    if (edge_n == cur.t0) exp_gnt = cur.win ? 2'b10 : 2'b01;
                    if (edge_n == cur.t0 + E + 2) begin
                        exp_done = cur.win ? 2'b10 : 2'b01;
                        ult_res  = cur.res;
                        ult_zero = cur.zero;
                        ptr      = !cur.win;
                        ativo    = 0;
                        livre    = edge_n + 2;
                    end
                end
            end
        end
    end

    // Monitor: sample mid-cycle, compare per-cycle expectations and pop transactions on Done.
    always @(negedge clock) begin
        if (!reset && edge_n > 0) begin
            chk("gnt", {30'd0, Gnt1, Gnt0}, {30'd0, exp_gnt});
            chk("done", {30'd0, Done1, Done0}, {30'd0, exp_done});
            chk("ocupado", {31'd0, Ocupado}, {31'd0, exp_busy});
            chk("entradas", {14'd0, ALUOp, Entrada1, Entrada2}, {14'd0, exp_op, exp_e1, exp_e2});
            chk("resultado_hold", {23'd0, ZeroOut, ResultadoOut}, {23'd0, ult_zero, ult_res});
            if (Gnt0 || Gnt1) begin
                gnt_log.push_back(Gnt1);
                chk("gnt_com_tr", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
                if (exp_q.size() > 0) chk("gnt_ciclo", edge_n, exp_q[0].t0);
            end
            if (Done0 || Done1) begin
                chk("done_com_tr", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
                if (exp_q.size() > 0) begin
                    tr_t tr;
                    tr = exp_q.pop_front();
                    chk("done_quem", {31'd0, Done1}, {31'd0, tr.win});
                    chk("done_ciclo", edge_n, tr.t0 + E + 2);
                    chk("done_res", {23'd0, ZeroOut, ResultadoOut}, {23'd0, tr.zero, tr.res});
                end
            end
        end
    end

    task automatic rand_ops();
        Op0 = 2'($urandom); Op1 = 2'($urandom);
        A0 = 8'($urandom); B0 = 8'($urandom);
        A1 = 8'($urandom); B1 = 8'($urandom);
        if ($urandom_range(0, 7) == 0) B0 = A0;
        if ($urandom_range(0, 7) == 0) B1 = A1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("rst_gnt_done", {28'd0, Gnt1, Gnt0, Done1, Done0}, 32'd0);
        chk("rst_saidas", {14'd0, ALUOp, Entrada1, Entrada2}, 32'd0);
        chk("rst_res", {23'd0, ZeroOut, ResultadoOut}, 32'd0);
        reset = 1'b0;

        // Both held from reset: grants alternate starting with requester 0
        gnt_log.delete();
        rand_ops();
        Req0 = 1'b1; Req1 = 1'b1;
        repeat (4 * (E + 4)) @(negedge clock);
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (E + 6) @(negedge clock);
        chk("rr_qtd", {31'd0, gnt_log.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            chk("rr_ordem", {31'd0, gnt_log[i]}, i % 2);
        end

        // Single request: 03 AND 04 gives zero; the result must hold while idle
        Op0 = 2'b10; A0 = 8'h03; B0 = 8'h04; Req0 = 1'b1;
        @(negedge clock);
        Req0 = 1'b0;
        repeat (E + 8) @(negedge clock);
        chk("zero_hold", {23'd0, ZeroOut, ResultadoOut}, {23'd0, 1'b1, 8'h00});

        // Random traffic; operands change freely while busy
        for (int i = 0; i < 400; i++) begin
            Req0 = ($urandom_range(0, 2) == 0);
            Req1 = ($urandom_range(0, 2) == 0);
            rand_ops();
            @(negedge clock);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (E + 6) @(negedge clock);

        // Reset in the middle of EXECUTA: outputs clear without a clock edge
        Op0 = 2'd0; A0 = 8'h11; B0 = 8'h22; Req0 = 1'b1;
        @(negedge clock);
        Req0 = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("rst_mid_done", {30'd0, Done1, Done0}, 32'd0);
        chk("rst_mid_entradas", {14'd0, ALUOp, Entrada1, Entrada2}, 32'd0);
        chk("rst_mid_res", {23'd0, ZeroOut, ResultadoOut}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 150; i++) begin
            Req0 = ($urandom_range(0, 1) == 0);
            Req1 = ($urandom_range(0, 1) == 0);
            rand_ops();
            @(negedge clock);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (E + 10) @(negedge clock);
        chk("fila_vazia", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
